multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Moore state-machine sequencer for the 16-bit multicycle datapath. It decodes the 4-bit opcode held in the instruction register and steps the datapath through fetch, decode, execute, memory and write-back phases. It emits the 16-bit control word whose bit layout the datapath muxes, register bank, ALU control and memory already consume. It also provides run/halt/single-step sequencing plus status (state, retired-instruction count, illegal-opcode flag) for the HEX/LCD debug path.

## Interface
- No parameters.
- clock  in  1  system clock (CLOCK_50 domain).
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  level; start/continue free-running execution.
- step  in  1  one-cycle pulse; advance one instruction (single-step build only).
- opcode  in  4  IR[15:12].
- ctl_word  out  16  control word: [0] RegDst, [1] EscreveReg, [2] OrigAALU, [4:3] OrigBALU, [6:5] OpALU, [7] LeMem, [8] EscreveMem, [9] MemparaReg, [10] IouD, [11] EscreveIR, [12] EscrevePC, [13] EscrevePCCond, [15:14] OrigPC.
- state  out  4  current state code.
- halted  out  1  high while in HALT.
- illegal  out  1  sticky; set on an undefined opcode in DECODE.
- instr_count  out  16  count of retired instructions, wraps at 0xFFFF -> 0x0000.

## Operation
- Opcodes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 slt (R-type), 0101 addi, 1000 lw, 1001 sw, 1100 j, 1101 beq, 1111 halt. All others are illegal.
- State codes and ctl_word values:
  - IDLE=15: 0x0000.
  - FETCH=0: 0x1888.
  - DECODE=1: 0x0018.
  - MEMADDR=2: 0x0014.
  - MEMREAD=3: 0x0480.
  - MEMWB=4: 0x0202.
  - MEMWRITE=5: 0x0500.
  - EXEC=6: 0x0044.
  - RWB=7: 0x0003.
  - IEXEC=8: 0x0014.
  - IWB=9: 0x0002.
  - HALT=10: 0x0000.
  - JUMP=12: 0x9000.
  - BRANCH=13: 0x6024.
- Transitions:
  - IDLE -> FETCH when run=1.
  - FETCH -> DECODE.
  - DECODE dispatches by opcode:
    - R-type -> EXEC -> RWB.
    - addi -> IEXEC -> IWB.
    - lw/sw -> MEMADDR; then lw -> MEMREAD -> MEMWB, sw -> MEMWRITE.
    - j -> JUMP.
    - beq -> BRANCH.
    - halt -> HALT.
    - illegal -> set illegal, go to FETCH, no retire.
- Terminal states (RWB, IWB, MEMWB, MEMWRITE, JUMP, BRANCH) retire: instr_count+1, then -> FETCH if run=1, else IDLE.
- HALT retires on entry and is left only by reset. run and step are ignored there.
- The branch-taken decision is the datapath's (EscrevePCCond & zero). The controller issues BRANCH identically for taken and not-taken branches.
- Reset (async, any state, mid-instruction included): state=IDLE, ctl_word=0x0000, halted=0, illegal=0, instr_count=0.

## Timing
- Moore outputs: ctl_word, state and halted are decoded from the state register only. They change just after posedge clock and are stable for the whole cycle.
- Cycles per instruction, FETCH through terminal state inclusive:
  - R-type 4, addi 4, sw 4, lw 5.
  - j 3, beq 3.
  - halt 2, then HALT holds.
- instr_count updates on the same edge that leaves the terminal state (HALT: the edge entering it).
- run is sampled only in IDLE and in terminal states. Dropping run mid-instruction completes the instruction, then parks in IDLE.
- opcode is sampled only in DECODE. The datapath holds IR stable from FETCH end through instruction end.

## Configuration
- SINGLE_STEP_EN defined:
  - IDLE -> FETCH only on step=1; run is ignored.
  - Every terminal state -> IDLE, so exactly one instruction executes per step pulse.
  - A step asserted while not in IDLE is dropped, not queued.
- Undefined: the step port is present but ignored; behaviour is as in Operation.

## Test plan
- Reset then run=1 with opcode=0000: state sequence 15,0,1,6,7,0. ctl_word reads 0x1888, 0x0018, 0x0044, 0x0003. instr_count=1 after 4 cycles of execution.
- opcode=1000 (lw), run=1: states 0,1,2,3,4 with ctl_word 0x1888, 0x0018, 0x0014, 0x0480, 0x0202. Then opcode=1001 (sw): states 0,1,2,5, with 0x0500 in MEMWRITE.
- opcode=1100, then 1101: states 0,1,12 with ctl_word 0x9000, then 0,1,13 with 0x6024. instr_count +2.
- opcode=0111 (illegal): illegal=1 after DECODE, next state 0, instr_count unchanged. illegal stays 1 until reset_n=0.
- opcode=1111: halted=1 at state 10, which persists for 100 cycles despite run/step toggling. instr_count +1. Assert reset_n=0 mid-hold: all outputs return to reset values immediately, without waiting for a clock edge.
- SINGLE_STEP_EN build, opcode=0000: the FSM stays in IDLE with run=1. Each step pulse yields exactly 15,0,1,6,7,15. A step pulse issued in EXEC is ignored.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: sequencing inputs and control/status outputs of the multicycle controller.
interface multicycle_ctrl_if;
    logic        run;
    logic        step;
    logic [3:0]  opcode;
    logic [15:0] ctl_word;
    logic [3:0]  state;
    logic        halted;
    logic        illegal;
    logic [15:0] instr_count;
    modport master (output run, step, opcode, input ctl_word, state, halted, illegal, instr_count);
    modport slave (input run, step, opcode, output ctl_word, state, halted, illegal, instr_count);
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM sequencer emitting the datapath control word plus debug status.
// Define SINGLE_STEP_EN to execute exactly one instruction per step pulse instead of free-running.
module multicycle_ctrl (
    input  logic             clock,
    input  logic             reset_n,
    multicycle_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADDR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
        MEMWRITE = 4'd5, EXEC = 4'd6, RWB = 4'd7, IEXEC = 4'd8, IWB = 4'd9,
        HALT = 4'd10, JUMP = 4'd12, BRANCH = 4'd13, IDLE = 4'd15
    } state_t;
    state_t      cur, nxt;
    logic        retire, bad_op, go, cont, is_store, ill;
    logic [15:0] cnt, cw;
`ifdef SINGLE_STEP_EN
    assign go   = bus.step;
    assign cont = 1'b0;
    logic unused_run;
    assign unused_run = bus.run;
`else
    assign go   = bus.run;
    assign cont = bus.run;
    logic unused_step;
    assign unused_step = bus.step;
`endif
    always_comb begin
        nxt    = cur;
        bad_op = 1'b0;
        retire = 1'b0;
        case (cur)
            IDLE:    nxt = go ? FETCH : IDLE;
            FETCH:   nxt = DECODE;
            DECODE:
                case (bus.opcode)
                    4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100: nxt = EXEC;
                    4'b0101:          nxt = IEXEC;
                    4'b1000, 4'b1001: nxt = MEMADDR;
                    4'b1100:          nxt = JUMP;
                    4'b1101:          nxt = BRANCH;
                    4'b1111: begin
                        nxt    = HALT;
                        retire = 1'b1;
                    end
                    default: begin
                        nxt    = FETCH;
                        bad_op = 1'b1;
                    end
                endcase
            MEMADDR: nxt = is_store ? MEMWRITE : MEMREAD;
            MEMREAD: nxt = MEMWB;
            EXEC:    nxt = RWB;
            IEXEC:   nxt = IWB;
            RWB, IWB, MEMWB, MEMWRITE, JUMP, BRANCH: begin
                nxt    = cont ? FETCH : IDLE;
                retire = 1'b1;
            end
            HALT:    nxt = HALT;
            default: nxt = IDLE;
        endcase
    end
    always_comb begin
        cw = 16'h0000;
        case (cur)
            FETCH:    cw = 16'h1888;
            DECODE:   cw = 16'h0018;
            MEMADDR:  cw = 16'h0014;
            MEMREAD:  cw = 16'h0480;
            MEMWB:    cw = 16'h0202;
            MEMWRITE: cw = 16'h0500;
            EXEC:     cw = 16'h0044;
            RWB:      cw = 16'h0003;
            IEXEC:    cw = 16'h0014;
            IWB:      cw = 16'h0002;
            JUMP:     cw = 16'h9000;
            BRANCH:   cw = 16'h6024;
            default:  cw = 16'h0000;
        endcase
    end
    // lw/sw split is latched in DECODE so the opcode is only looked at there
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur      <= IDLE;
            ill      <= 1'b0;
            cnt      <= 16'h0000;
            is_store <= 1'b0;
        end else begin
            cur <= nxt;
            ill <= ill | bad_op;
            cnt <= cnt + 16'(retire);
            if (cur == DECODE) is_store <= bus.opcode[0];
        end
    end
    assign bus.ctl_word    = cw;
    assign bus.state       = cur;
    assign bus.halted      = (cur == HALT);
    assign bus.illegal     = ill;
    assign bus.instr_count = cnt;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed instruction sequences checked cycle by cycle through a scoreboard.
module tb_multicycle_ctrl;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    multicycle_ctrl_if bus();
    multicycle_ctrl dut (.clock(clock), .reset_n(reset_n), .bus(bus));
    always #5 clock = ~clock;
    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] cw;
        logic        h;
        logic        il;
        logic [15:0] cnt;
    } exp_t;
    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic        il_e = 1'b0;
    logic [15:0] cnt_e = 16'h0000;
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // Expected outputs for the current cycle, then advance to just after the next edge
    task automatic cyc(input logic [3:0] st, input logic [15:0] cw);
        sb.push_back('{st, cw, st == 4'd10, il_e, cnt_e});
        @(posedge clock);
        #1;
    endtask
    always @(negedge clock) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("state", 16'(bus.state), 16'(e.st));
            chk("ctl_word", bus.ctl_word, e.cw);
            chk("halted", 16'(bus.halted), 16'(e.h));
            chk("illegal", 16'(bus.illegal), 16'(e.il));
            chk("instr_count", bus.instr_count, e.cnt);
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.run = 1'b0;
        bus.step = 1'b0;
        bus.opcode = 4'b0000;
        repeat (2) @(posedge clock);
        #1;
        cyc(4'd15, 16'h0000);
        reset_n = 1'b1;
`ifdef SINGLE_STEP_EN
        bus.run = 1'b1;
        cyc(4'd15, 16'h0000);
        cyc(4'd15, 16'h0000);
        for (int k = 0; k < 2; k++) begin
            bus.step = 1'b1;
            cyc(4'd15, 16'h0000);
            bus.step = 1'b0;
            cyc(4'd0, 16'h1888);
            cyc(4'd1, 16'h0018);
            bus.step = 1'b1;
            cyc(4'd6, 16'h0044);
            bus.step = 1'b0;
            cyc(4'd7, 16'h0003);
            cnt_e++;
            cyc(4'd15, 16'h0000);
            cyc(4'd15, 16'h0000);
        end
`else
        cyc(4'd15, 16'h0000);
        bus.run = 1'b1;
        cyc(4'd15, 16'h0000);
        cyc(4'd0, 16'h1888);
        cyc(4'd1, 16'h0018);
        cyc(4'd6, 16'h0044);
        cyc(4'd7, 16'h0003);
        cnt_e++;
        bus.opcode = 4'b1000;
        cyc(4'd0, 16'h1888);
        cyc(4'd1, 16'h0018);
        cyc(4'd2, 16'h0014);
        cyc(4'd3, 16'h0480);
        cyc(4'd4, 16'h0202);
        cnt_e++;
        bus.opcode = 4'b1001;
        cyc(4'd0, 16'h1888);
        cyc(4'd1, 16'h0018);
        cyc(4'd2, 16'h0014);
        cyc(4'd5, 16'h0500);
        cnt_e++;
        bus.opcode = 4'b1100;
        cyc(4'd0, 16'h1888);
        cyc(4'd1, 16'h0018);
        cyc(4'd12, 16'h9000);
        cnt_e++;
        bus.opcode = 4'b1101;
        cyc(4'd0, 16'h1888);
        cyc(4'd1, 16'h0018);
        cyc(4'd13, 16'h6024);
        cnt_e++;
        bus.opcode = 4'b0111;
        cyc(4'd0, 16'h1888);
        cyc(4'd1, 16'h0018);
        il_e = 1'b1;
        bus.opcode = 4'b0011;
        cyc(4'd0, 16'h1888);
        cyc(4'd1, 16'h0018);
        cyc(4'd6, 16'h0044);
        bus.run = 1'b0;
        cyc(4'd7, 16'h0003);
        cnt_e++;
        cyc(4'd15, 16'h0000);
        cyc(4'd15, 16'h0000);
        bus.run = 1'b1;
        cyc(4'd15, 16'h0000);
        bus.opcode = 4'b0101;
        cyc(4'd0, 16'h1888);
        bus.run = 1'b0;
        cyc(4'd1, 16'h0018);
        cyc(4'd8, 16'h0014);
        cyc(4'd9, 16'h0002);
        cnt_e++;
        cyc(4'd15, 16'h0000);
        bus.run = 1'b1;
        cyc(4'd15, 16'h0000);
        bus.opcode = 4'b1111;
        cyc(4'd0, 16'h1888);
        cyc(4'd1, 16'h0018);
        cnt_e++;
        for (int i = 0; i < 100; i++) begin
            bus.run = i[0];
            bus.step = i[1];
            cyc(4'd10, 16'h0000);
        end
`endif
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_state", 16'(bus.state), 16'd15);
        chk("async_rst_ctl_word", bus.ctl_word, 16'h0000);
        chk("async_rst_halted", 16'(bus.halted), 16'd0);
        chk("async_rst_illegal", 16'(bus.illegal), 16'd0);
        chk("async_rst_count", bus.instr_count, 16'h0000);
        @(negedge clock);
        chk("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
